// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : PC / fetch control with absolute and relative branches,
//                call/return through a circular return-address stack, stall,
//                and a sticky HALTED state released by Resume.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic             CLK,
    input  logic             Init_n,
    input  logic             Halt,
    input  logic             Resume,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             RelBranch,
    input  logic             Call,
    input  logic             Ret,
    input  logic [PC_W-1:0]  Target,
    input  logic [OFF_W-1:0] Offset,
    output logic [PC_W-1:0]  PC,
    output logic             Halted,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasErr
);

    localparam int c_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PC_W-1:0]    c_RESET_PC = PC_W'(RESET_PC);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(RAS_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(RAS_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_ras [RAS_DEPTH];
    logic [c_PTR_W-1:0] r_top;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err;

    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_pc_rel;
    logic [PC_W-1:0]    w_off_ext;
    logic [c_PTR_W-1:0] w_top_inc;
    logic [c_PTR_W-1:0] w_top_dec;
    logic               w_empty;
    logic               w_full;

    assign w_off_ext = {{(PC_W - OFF_W){Offset[OFF_W-1]}}, Offset};
    assign w_pc_inc  = r_pc + 1'b1;
    assign w_pc_rel  = r_pc + w_off_ext;
    // Pointer wraps explicitly so non-power-of-two depths stay in range
    assign w_top_inc = (r_top == c_PTR_LAST) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? c_PTR_LAST : r_top - 1'b1;
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == c_CNT_FULL);

    always_ff @(posedge CLK) begin
        if (!Init_n) begin
            r_state <= ST_RUN;
            r_pc    <= c_RESET_PC;
            r_top   <= c_PTR_LAST;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (Halt) begin
                        r_state <= ST_HALTED;
                    end else if (Stall) begin
                        r_pc <= r_pc;
                    end else if (Ret) begin
                        if (!w_empty) begin
                            r_pc  <= r_ras[r_top];
                            r_top <= w_top_dec;
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_pc  <= w_pc_inc;
                            r_err <= 1'b1;
                        end
                    end else if (Call) begin
                        // When full, the slot after top is the oldest entry
                        r_ras[w_top_inc] <= w_pc_inc;
                        r_top            <= w_top_inc;
                        r_pc             <= Target;
                        if (w_full) r_err <= 1'b1;
                        else        r_cnt <= r_cnt + 1'b1;
                    end else if (Branch) begin
                        r_pc <= Target;
                    end else if (RelBranch) begin
                        r_pc <= w_pc_rel;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                ST_HALTED: begin
                    if (Resume) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign PC       = r_pc;
    assign Halted   = (r_state == ST_HALTED);
    assign RasEmpty = w_empty;
    assign RasFull  = w_full;
    assign RasErr   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Vector table, directed corner sequences and random stimulus
//                checked against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic       CLK = 1'b0;
    logic       Init_n, Halt, Resume, Stall, Branch, RelBranch, Call, Ret;
    logic [7:0] Target;
    logic [4:0] Offset;
    logic [7:0] PC;
    logic       Halted, RasEmpty, RasFull, RasErr;

    fetch_unit #(.PC_W(8), .OFF_W(5), .RAS_DEPTH(4), .RESET_PC(0)) dut (
        .CLK(CLK), .Init_n(Init_n), .Halt(Halt), .Resume(Resume), .Stall(Stall),
        .Branch(Branch), .RelBranch(RelBranch), .Call(Call), .Ret(Ret),
        .Target(Target), .Offset(Offset), .PC(PC), .Halted(Halted),
        .RasEmpty(RasEmpty), .RasFull(RasFull), .RasErr(RasErr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       init_n, halt, resume, stall, branch, relb, call, ret;
        logic [7:0] target;
        logic [4:0] offset;
    } ctl_t;

    typedef struct {
        ctl_t       c;
        logic [7:0] pc;
        logic       h, e, f, err;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_pc;
    bit m_halted;
    bit m_err;
    int m_ras[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ctl_t mk(input string op, input logic [7:0] arg);
        ctl_t c = '{init_n: 1'b1, halt: 1'b0, resume: 1'b0, stall: 1'b0, branch: 1'b0,
                    relb: 1'b0, call: 1'b0, ret: 1'b0, target: 8'h00, offset: 5'h00};
        case (op)
            "rst":  c.init_n = 1'b0;
            "br":   begin c.branch = 1'b1; c.target = arg; end
            "rel":  begin c.relb = 1'b1; c.offset = arg[4:0]; end
            "call": begin c.call = 1'b1; c.target = arg; end
            "ret":  c.ret = 1'b1;
            "halt": c.halt = 1'b1;
            "res":  c.resume = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic vec_t v(input string op, input logic [7:0] arg, input logic [7:0] pc,
                               input logic h, input logic e, input logic f, input logic err);
        vec_t r;
        r.c = mk(op, arg); r.pc = pc; r.h = h; r.e = e; r.f = f; r.err = err;
        return r;
    endfunction

    task automatic model_update(input ctl_t c);
        int off;
        if (!c.init_n) begin
            m_pc = 0; m_halted = 0; m_err = 0; m_ras.delete();
        end else if (m_halted) begin
            if (c.resume) m_halted = 0;
        end else if (c.halt) begin
            m_halted = 1;
        end else if (c.stall) begin
            // hold everything
        end else if (c.ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin m_pc = (m_pc + 1) % 256; m_err = 1; end
        end else if (c.call) begin
            m_ras.push_back((m_pc + 1) % 256);
            if (m_ras.size() > 4) begin void'(m_ras.pop_front()); m_err = 1; end
            m_pc = int'(c.target);
        end else if (c.branch) begin
            m_pc = int'(c.target);
        end else if (c.relb) begin
            off = int'(c.offset);
            if (off >= 16) off -= 32;
            m_pc = (m_pc + off + 256) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    // Drive one cycle, advance the model, and compare DUT against it
    task automatic step(input ctl_t c);
        Init_n = c.init_n; Halt = c.halt; Resume = c.resume; Stall = c.stall;
        Branch = c.branch; RelBranch = c.relb; Call = c.call; Ret = c.ret;
        Target = c.target; Offset = c.offset;
        @(posedge CLK);
        model_update(c);
        #1;
        chk("model_pc", int'(PC), m_pc);
        chk("model_halted", int'(Halted), int'(m_halted));
        chk("model_empty", int'(RasEmpty), int'(m_ras.size() == 0));
        chk("model_full", int'(RasFull), int'(m_ras.size() == 4));
        chk("model_err", int'(RasErr), int'(m_err));
    endtask

    task automatic expect_state(input string name, input logic [7:0] pc, input logic h,
                                input logic e, input logic f, input logic err);
        chk({name, "_pc"}, int'(PC), int'(pc));
        chk({name, "_halted"}, int'(Halted), int'(h));
        chk({name, "_empty"}, int'(RasEmpty), int'(e));
        chk({name, "_full"}, int'(RasFull), int'(f));
        chk({name, "_err"}, int'(RasErr), int'(err));
    endtask

    vec_t vecs[$];
    ctl_t c;

    initial begin
        m_pc = 0; m_halted = 0; m_err = 0;

        // Reset, idle counting, wrap, relative branches, call/return
        vecs.push_back(v("rst",  8'h00, 8'h00, 0, 1, 0, 0));
        vecs.push_back(v("rst",  8'h00, 8'h00, 0, 1, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h01, 0, 1, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h02, 0, 1, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h03, 0, 1, 0, 0));
        vecs.push_back(v("br",   8'hFF, 8'hFF, 0, 1, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h00, 0, 1, 0, 0));
        vecs.push_back(v("br",   8'h10, 8'h10, 0, 1, 0, 0));
        vecs.push_back(v("rel",  8'h1E, 8'h0E, 0, 1, 0, 0));
        vecs.push_back(v("br",   8'h10, 8'h10, 0, 1, 0, 0));
        vecs.push_back(v("rel",  8'h0F, 8'h1F, 0, 1, 0, 0));
        vecs.push_back(v("br",   8'h05, 8'h05, 0, 1, 0, 0));
        vecs.push_back(v("call", 8'h40, 8'h40, 0, 0, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h41, 0, 0, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h42, 0, 0, 0, 0));
        vecs.push_back(v("idle", 8'h00, 8'h43, 0, 0, 0, 0));
        vecs.push_back(v("ret",  8'h00, 8'h06, 0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c);
            expect_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].h, vecs[i].e,
                         vecs[i].f, vecs[i].err);
        end

        // RAS overflow and underflow
        step(mk("rst", 8'h00));
        for (int i = 0; i < 5; i++) begin
            step(mk("br", 8'h10 + 8'(i)));
            step(mk("call", 8'h80));
            if (i == 3) expect_state("ovf_4th", 8'h80, 0, 0, 1, 0);
            if (i == 4) expect_state("ovf_5th", 8'h80, 0, 0, 1, 1);
        end
        step(mk("ret", 8'h00)); expect_state("ret1", 8'h15, 0, 0, 0, 1);
        step(mk("ret", 8'h00)); expect_state("ret2", 8'h14, 0, 0, 0, 1);
        step(mk("ret", 8'h00)); expect_state("ret3", 8'h13, 0, 0, 0, 1);
        step(mk("ret", 8'h00)); expect_state("ret4", 8'h12, 0, 1, 0, 1);
        step(mk("ret", 8'h00)); expect_state("ret_empty", 8'h13, 0, 1, 0, 1);

        // Halt wins over same-cycle branch; inputs ignored while halted
        step(mk("rst", 8'h00));
        step(mk("br", 8'h20));
        c = mk("br", 8'h90); c.halt = 1'b1;
        step(c); expect_state("halt_entry", 8'h20, 1, 1, 0, 0);
        step(mk("br", 8'h90));   expect_state("halted_br", 8'h20, 1, 1, 0, 0);
        step(mk("call", 8'h90)); expect_state("halted_call", 8'h20, 1, 1, 0, 0);
        c = mk("call", 8'h90); c.branch = 1'b1; c.ret = 1'b1;
        step(c); expect_state("halted_mix", 8'h20, 1, 1, 0, 0);
        c = mk("res", 8'h00); c.halt = 1'b1;
        step(c); expect_state("resume", 8'h20, 0, 1, 0, 0);
        step(mk("idle", 8'h00)); expect_state("after_resume", 8'h21, 0, 1, 0, 0);
        step(mk("res", 8'h00)); expect_state("resume_in_run", 8'h22, 0, 1, 0, 0);

        // Stall beats Call+Ret; reset while halted with entries on the stack
        step(mk("rst", 8'h00));
        step(mk("call", 8'h30)); expect_state("pre_stall", 8'h30, 0, 0, 0, 0);
        c = mk("call", 8'h55); c.stall = 1'b1; c.ret = 1'b1;
        step(c); expect_state("stall", 8'h30, 0, 0, 0, 0);
        step(mk("ret", 8'h00)); expect_state("post_stall_ret", 8'h01, 0, 1, 0, 0);
        step(mk("call", 8'h40));
        step(mk("call", 8'h50));
        step(mk("call", 8'h60));
        step(mk("halt", 8'h00)); expect_state("halt3", 8'h60, 1, 0, 0, 0);
        step(mk("rst", 8'h00));  expect_state("rst_halted", 8'h00, 0, 1, 0, 0);

        // Random stimulus against the reference model
        for (int n = 0; n < 3000; n++) begin
            c.init_n = ($urandom_range(0, 99) != 0);
            c.halt   = ($urandom_range(0, 19) == 0);
            c.resume = ($urandom_range(0, 3) == 0);
            c.stall  = ($urandom_range(0, 7) == 0);
            c.ret    = ($urandom_range(0, 3) == 0);
            c.call   = ($urandom_range(0, 3) == 0);
            c.branch = ($urandom_range(0, 3) == 0);
            c.relb   = ($urandom_range(0, 2) == 0);
            c.target = 8'($urandom);
            c.offset = 5'($urandom);
            step(c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
